// File: rtl/lc3_mio.sv
// lc3_mio: LC-3 memory/IO controller bridging CPU accesses to RAM, keyboard, display and MCR.
module lc3_mio (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        done,
  output logic        err,
  output logic        MEM_EN,
  output logic        R_W,
  output logic [15:0] a,
  output logic [15:0] d_in,
  input  logic [15:0] d_out,
  input  logic        R,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        disp_valid,
  output logic [7:0]  disp_data,
  input  logic        disp_ready,
  output logic        mcr_run
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [15:0] kbdr, mcr, io_rdata;
  logic kb_rdy, kb_ovr, is_io, rd, wr, kbdr_rd;
  assign is_io = &addr[15:9];
  assign rd = state == IDLE && req && is_io && !we;
  assign wr = state == IDLE && req && is_io && we;
  assign kbdr_rd = rd && addr == 16'hFE02;
  assign mcr_run = mcr[15];
  assign io_rdata = addr == 16'hFE00 ? {kb_rdy, kb_ovr, 14'b0} :
                    addr == 16'hFE02 ? kbdr :
                    addr == 16'hFE04 ? {~disp_valid, 15'b0} :
                    addr == 16'hFE06 ? {8'h00, disp_data} :
                    addr == 16'hFFFE ? mcr : 16'h0000;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= 4'd0;
      rdata <= 16'h0000;
      done <= 1'b0;
      err <= 1'b0;
      MEM_EN <= 1'b0;
      R_W <= 1'b0;
      a <= 16'h0000;
      d_in <= 16'h0000;
      kbdr <= 16'h0000;
      kb_rdy <= 1'b0;
      kb_ovr <= 1'b0;
      disp_valid <= 1'b0;
      disp_data <= 8'h00;
      mcr <= 16'h8000;
    end else begin
      MEM_EN <= 1'b0;
      R_W <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (req) begin
          if (is_io) begin
            state <= DONE;
            done <= 1'b1;
            err <= 1'b0;
            rdata <= io_rdata;
          end else begin
            state <= ISSUE;
            MEM_EN <= 1'b1;
            R_W <= we;
            a <= addr;
            d_in <= wdata;
          end
        end
        ISSUE: begin
          state <= WAIT;
          cnt <= 4'd0;
        end
        WAIT: if (R) begin
          state <= DONE;
          done <= 1'b1;
          err <= 1'b0;
          rdata <= d_out;
        end else if (cnt == 4'd14) begin
          state <= DONE;
          done <= 1'b1;
          err <= 1'b1;
          rdata <= 16'h0000;
        end else cnt <= cnt + 4'd1;
        DONE: state <= IDLE;
      endcase
      if (rd && addr == 16'hFE00) kb_ovr <= 1'b0;
      if (kbdr_rd) kb_rdy <= 1'b0;
      // a same-cycle KBDR read frees the slot, so the arriving char is taken, not dropped
      if (kb_valid && (!kb_rdy || kbdr_rd)) begin
        kbdr <= {8'h00, kb_data};
        kb_rdy <= 1'b1;
      end else if (kb_valid) kb_ovr <= 1'b1;
      if (disp_valid && disp_ready) disp_valid <= 1'b0;
      if (wr && addr == 16'hFE06 && !disp_valid) begin
        disp_valid <= 1'b1;
        disp_data <= wdata[7:0];
      end
      if (wr && addr == 16'hFFFE) mcr <= wdata;
    end
  end
endmodule

// File: tb/tb_lc3_mio.sv
// tb_lc3_mio: directed checks of lc3_mio against a one-cycle-ready RAM model.
module tb_lc3_mio;
  logic clk = 0, rst_n = 0, req = 0, we = 0;
  logic [15:0] addr = 0, wdata = 0, rdata, a, d_in, d_out;
  logic done, err, MEM_EN, R_W, R, disp_valid, mcr_run;
  logic kb_valid = 0, disp_ready = 0, stall = 0, men0;
  logic [7:0] kb_data = 0, disp_data;
  logic [15:0] mem [0:65535];
  logic [15:0] rv;
  logic ev;
  int lat, checks = 0, errors = 0, dn;

  lc3_mio dut (.clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .done(done), .err(err), .MEM_EN(MEM_EN), .R_W(R_W), .a(a), .d_in(d_in),
    .d_out(d_out), .R(R), .kb_valid(kb_valid), .kb_data(kb_data), .disp_valid(disp_valid),
    .disp_data(disp_data), .disp_ready(disp_ready), .mcr_run(mcr_run));

  always #5 clk = ~clk;

  initial begin
    R = 0;
    d_out = 0;
  end
  always @(posedge clk) begin
    if (MEM_EN && !stall) begin
      R <= 1'b1;
      d_out <= mem[a];
      if (R_W) mem[a] <= d_in;
    end else R <= 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic acc(input logic w, input logic [15:0] ad, input logic [15:0] wd,
                     output logic [15:0] r, output logic e, output int l);
    req = 1; we = w; addr = ad; wdata = wd;
    @(posedge clk); #1;
    req = 0; kb_valid = 0; men0 = MEM_EN;
    l = 1;
    while (!done && l < 40) begin
      @(posedge clk); #1;
      l++;
    end
    r = rdata; e = err;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    mem[16'h3000] = 16'h1234;
    #12;
    chk("rst_rdata", rdata, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_en", MEM_EN, 0);
    chk("rst_a", a, 0);
    chk("rst_disp_valid", disp_valid, 0);
    chk("rst_mcr_run", mcr_run, 1);
    @(negedge clk) rst_n = 1;
    @(negedge clk);
    acc(0, 16'h3000, 0, rv, ev, lat);
    chk("ram_rd_men", men0, 1);
    chk("ram_rd_lat", lat, 3);
    chk("ram_rd_data", rv, 16'h1234);
    chk("ram_rd_err", ev, 0);
    acc(1, 16'h3001, 16'h5A5A, rv, ev, lat);
    chk("ram_wr_lat", lat, 3);
    chk("ram_wr_mem", mem[16'h3001], 16'h5A5A);
    acc(0, 16'h3001, 0, rv, ev, lat);
    chk("ram_rd2_data", rv, 16'h5A5A);
    stall = 1;
    acc(0, 16'h3002, 0, rv, ev, lat);
    stall = 0;
    chk("tmo_lat", lat, 17);
    chk("tmo_err", ev, 1);
    chk("tmo_data", rv, 0);
    kb_valid = 1; kb_data = 8'h41;
    @(negedge clk) kb_data = 8'h42;
    @(negedge clk) kb_valid = 0;
    acc(0, 16'hFE00, 0, rv, ev, lat);
    chk("kbsr_ovr", rv, 16'hC000);
    chk("io_lat", lat, 1);
    chk("io_err", ev, 0);
    acc(0, 16'hFE00, 0, rv, ev, lat);
    chk("kbsr_rdy", rv, 16'h8000);
    acc(0, 16'hFE02, 0, rv, ev, lat);
    chk("kbdr_a", rv, 16'h0041);
    acc(0, 16'hFE00, 0, rv, ev, lat);
    chk("kbsr_empty", rv, 16'h0000);
    kb_valid = 1; kb_data = 8'h43;
    @(negedge clk) kb_data = 8'h44;
    acc(0, 16'hFE02, 0, rv, ev, lat);
    chk("kbdr_race_old", rv, 16'h0043);
    acc(0, 16'hFE00, 0, rv, ev, lat);
    chk("kbsr_race", rv, 16'h8000);
    acc(0, 16'hFE02, 0, rv, ev, lat);
    chk("kbdr_race_new", rv, 16'h0044);
    acc(1, 16'hFE06, 16'h0048, rv, ev, lat);
    chk("ddr_valid", disp_valid, 1);
    acc(0, 16'hFE04, 0, rv, ev, lat);
    chk("dsr_busy", rv, 16'h0000);
    acc(1, 16'hFE06, 16'h0049, rv, ev, lat);
    chk("ddr_ignored", disp_data, 8'h48);
    acc(0, 16'hFE06, 0, rv, ev, lat);
    chk("ddr_read", rv, 16'h0048);
    disp_ready = 1;
    @(posedge clk); #1;
    chk("disp_clear", disp_valid, 0);
    disp_ready = 0;
    @(negedge clk);
    acc(0, 16'hFE04, 0, rv, ev, lat);
    chk("dsr_ready", rv, 16'h8000);
    chk("disp_data_kept", disp_data, 8'h48);
    acc(1, 16'hFE10, 16'hBEEF, rv, ev, lat);
    acc(0, 16'hFE10, 0, rv, ev, lat);
    chk("unmapped_rd", rv, 0);
    chk("unmapped_err", ev, 0);
    acc(0, 16'hFFFE, 0, rv, ev, lat);
    chk("mcr_rst_val", rv, 16'h8000);
    acc(1, 16'hFFFE, 16'h0000, rv, ev, lat);
    chk("mcr_run_off", mcr_run, 0);
    acc(0, 16'hFFFE, 0, rv, ev, lat);
    chk("mcr_read0", rv, 16'h0000);
    req = 1; we = 0; addr = 16'h3000;
    @(posedge clk); #1;
    req = 0;
    @(posedge clk); #1;
    rst_n = 0;
    #2;
    chk("abort_men", MEM_EN, 0);
    chk("abort_mcr_run", mcr_run, 1);
    rst_n = 1;
    dn = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("abort_no_done", dn, 0);
    @(negedge clk);
    acc(0, 16'h3000, 0, rv, ev, lat);
    chk("post_abort_data", rv, 16'h1234);
    chk("post_abort_lat", lat, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
